// File: rtl/cap_trig_ctrl.sv
// Trigger/store sequencer for the debug capture path: writes the capture stream into a
// circular SRAM, detects a trigger and stops after a programmed post-trigger count.
module cap_trig_ctrl #(
    parameter int AW  = 10,
    parameter int PLW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [31:0]    cap_data,
    input  logic           cap_data_vld,
    input  logic           cap_mode_vld,
    input  logic           cfg_arm,
    input  logic           cfg_abort,
    input  logic [31:0]    cfg_trig_val,
    input  logic [31:0]    cfg_trig_mask,
    input  logic           cfg_trig_en,
    input  logic           ext_trig,
    input  logic [PLW-1:0] cfg_post_len,
    output logic           mem_wr_en,
    output logic [AW-1:0]  mem_waddr,
    output logic [31:0]    mem_wdata,
    output logic           cap_busy,
    output logic           cap_done,
    output logic           cap_err,
    output logic [AW-1:0]  trig_addr,
    output logic           wrapped
);

    localparam int            XW      = (PLW > AW) ? PLW : AW;
    localparam logic [AW-1:0] PTR_MAX = {AW{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] ptr;
    logic [AW-1:0] post_cnt;
    logic [AW-1:0] post_clamp;
    logic [XW-1:0] len_x;
    logic [XW-1:0] lim_x;
    logic          pending;
    logic          match;
    logic          trig_evt;
    logic          arm_go;
    logic          wr_fire;
    logic          trig_fire;
    logic          dec_cnt;
    logic          enter_err;

    // Clamping to 2^AW-1 keeps the trigger sample from being overwritten before DONE.
    assign len_x      = XW'(cfg_post_len);
    assign lim_x      = XW'(PTR_MAX);
    assign post_clamp = (len_x > lim_x) ? PTR_MAX : len_x[AW-1:0];

    assign match    = cfg_trig_en & (((cap_data ^ cfg_trig_val) & cfg_trig_mask) == 32'd0);
    assign trig_evt = cap_data_vld & (match | pending | ext_trig);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        arm_go    = 1'b0;
        wr_fire   = 1'b0;
        trig_fire = 1'b0;
        dec_cnt   = 1'b0;
        enter_err = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (cfg_arm) begin
                    state_nx = ARMED;
                    arm_go   = 1'b1;
                end
            end
            ARMED: begin
                if (cfg_abort) begin
                    state_nx = IDLE;
                end else if (!cap_mode_vld) begin
                    state_nx  = IDLE;
                    enter_err = 1'b1;
                end else if (cap_data_vld) begin
                    wr_fire = 1'b1;
                    if (trig_evt) begin
                        trig_fire = 1'b1;
                        state_nx  = (post_clamp == '0) ? DONE : POST;
                    end
                end
            end
            POST: begin
                if (cfg_abort) begin
                    state_nx = IDLE;
                end else if (!cap_mode_vld) begin
                    state_nx  = IDLE;
                    enter_err = 1'b1;
                end else if (cap_data_vld) begin
                    wr_fire = 1'b1;
                    dec_cnt = 1'b1;
                    if (post_cnt == AW'(1)) begin
                        state_nx = DONE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_en <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            cap_busy  <= 1'b0;
            cap_done  <= 1'b0;
            cap_err   <= 1'b0;
            trig_addr <= '0;
            wrapped   <= 1'b0;
            ptr       <= '0;
            post_cnt  <= '0;
            pending   <= 1'b0;
        end else begin
            mem_wr_en <= wr_fire;
            cap_busy  <= (state_nx == ARMED) || (state_nx == POST);
            if (arm_go) begin
                ptr       <= '0;
                mem_waddr <= '0;
                wrapped   <= 1'b0;
                cap_done  <= 1'b0;
                cap_err   <= 1'b0;
                trig_addr <= '0;
                pending   <= 1'b0;
            end else begin
                // cap_done follows the DONE state register, one cycle after the final write.
                if (state == DONE) begin
                    cap_done <= 1'b1;
                end
                if (enter_err) begin
                    cap_err <= 1'b1;
                end
                if (wr_fire) begin
                    mem_waddr <= ptr;
                    mem_wdata <= cap_data;
                    ptr       <= ptr + AW'(1);
                    if (ptr == PTR_MAX) begin
                        wrapped <= 1'b1;
                    end
                end
                if (state == ARMED) begin
                    if (trig_fire) begin
                        pending <= 1'b0;
                    end else if (ext_trig) begin
                        pending <= 1'b1;
                    end
                end
                if (trig_fire) begin
                    trig_addr <= ptr;
                    post_cnt  <= post_clamp;
                end else if (dec_cnt) begin
                    post_cnt <= post_cnt - AW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cap_trig_ctrl.sv
// Directed and randomized bench for cap_trig_ctrl, compared cycle by cycle against a
// behavioural capture model.
module tb_cap_trig_ctrl;

    localparam int AW    = 10;
    localparam int PLW   = 16;
    localparam int DEPTH = 1 << AW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [31:0]    cap_data = '0;
    logic           cap_data_vld = 1'b0;
    logic           cap_mode_vld = 1'b1;
    logic           cfg_arm = 1'b0;
    logic           cfg_abort = 1'b0;
    logic [31:0]    cfg_trig_val = '0;
    logic [31:0]    cfg_trig_mask = '0;
    logic           cfg_trig_en = 1'b0;
    logic           ext_trig = 1'b0;
    logic [PLW-1:0] cfg_post_len = '0;
    logic           mem_wr_en;
    logic [AW-1:0]  mem_waddr;
    logic [31:0]    mem_wdata;
    logic           cap_busy;
    logic           cap_done;
    logic           cap_err;
    logic [AW-1:0]  trig_addr;
    logic           wrapped;

    cap_trig_ctrl #(.AW(AW), .PLW(PLW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cap_data(cap_data), .cap_data_vld(cap_data_vld), .cap_mode_vld(cap_mode_vld),
        .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
        .cfg_trig_val(cfg_trig_val), .cfg_trig_mask(cfg_trig_mask), .cfg_trig_en(cfg_trig_en),
        .ext_trig(ext_trig), .cfg_post_len(cfg_post_len),
        .mem_wr_en(mem_wr_en), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .cap_busy(cap_busy), .cap_done(cap_done), .cap_err(cap_err),
        .trig_addr(trig_addr), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: a capture is "active" until it finishes, aborts or errors.
    bit m_active, m_trig, m_pending, m_in_done, m_done, m_err, m_wrapped, m_we;
    int m_ptr, m_trig_addr, m_remaining, m_wa;
    logic [31:0] m_wd;

    // Observation bookkeeping for the directed scenarios.
    int cyc, wr_count, last_wa, last_wr_cyc, done_cyc;
    bit done_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_active = 0; m_trig = 0; m_pending = 0; m_in_done = 0; m_done = 0;
        m_err = 0; m_wrapped = 0; m_we = 0; m_ptr = 0; m_trig_addr = 0;
        m_remaining = 0; m_wa = 0; m_wd = '0;
    endfunction

    function automatic void model_write();
        m_we  = 1;
        m_wa  = m_ptr;
        m_wd  = cap_data;
        m_ptr = (m_ptr + 1) % DEPTH;
        if (m_ptr == 0) m_wrapped = 1;
    endfunction

    function automatic void model_step();
        bit hit;
        m_we = 0;
        if (!m_active) begin
            if (cfg_arm) begin
                m_active = 1; m_trig = 0; m_ptr = 0; m_wrapped = 0; m_done = 0;
                m_in_done = 0; m_err = 0; m_trig_addr = 0; m_pending = 0;
            end else if (m_in_done) begin
                m_done = 1;
            end
        end else if (cfg_abort) begin
            m_active = 0;
        end else if (!cap_mode_vld) begin
            m_active = 0;
            m_err    = 1;
        end else if (!m_trig) begin
            hit = cap_data_vld && ((cfg_trig_en && (((cap_data ^ cfg_trig_val) & cfg_trig_mask) == 0))
                                   || m_pending || ext_trig);
            if (ext_trig && !cap_data_vld) m_pending = 1;
            if (hit) begin
                m_trig_addr = m_ptr;
                m_pending   = 0;
                m_remaining = (int'(cfg_post_len) > DEPTH - 1) ? DEPTH - 1 : int'(cfg_post_len);
            end
            if (cap_data_vld) model_write();
            if (hit) begin
                if (m_remaining == 0) begin
                    m_active  = 0;
                    m_in_done = 1;
                end else begin
                    m_trig = 1;
                end
            end
        end else if (cap_data_vld) begin
            model_write();
            m_remaining--;
            if (m_remaining == 0) begin
                m_active  = 0;
                m_in_done = 1;
            end
        end
    endfunction

    task automatic compare_all();
        chk("wr_en", {31'd0, mem_wr_en}, {31'd0, m_we});
        if (m_we) begin
            chk("waddr", 32'(mem_waddr), 32'(m_wa));
            chk("wdata", mem_wdata, m_wd);
        end
        chk("busy", {31'd0, cap_busy}, {31'd0, m_active});
        chk("done", {31'd0, cap_done}, {31'd0, m_done});
        chk("err", {31'd0, cap_err}, {31'd0, m_err});
        chk("trig_addr", 32'(trig_addr), 32'(m_trig_addr));
        chk("wrapped", {31'd0, wrapped}, {31'd0, m_wrapped});
        if (mem_wr_en) begin
            wr_count++;
            last_wa     = int'(mem_waddr);
            last_wr_cyc = cyc;
        end
        if (cap_done && !done_seen) begin
            done_seen = 1;
            done_cyc  = cyc;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        compare_all();
        cfg_arm   = 1'b0;
        cfg_abort = 1'b0;
        ext_trig  = 1'b0;
    endtask

    task automatic smp(input logic v, input logic [31:0] d);
        cap_data_vld = v;
        cap_data     = d;
        tick();
    endtask

    task automatic track_clear();
        wr_count = 0; last_wa = -1; last_wr_cyc = -1; done_cyc = -1; done_seen = 0;
    endtask

    task automatic arm();
        track_clear();
        cfg_arm = 1'b1;
        smp(1'b0, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr_en"}, {31'd0, mem_wr_en}, 32'd0);
        chk({tag, "_waddr"}, 32'(mem_waddr), 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_busy"}, {31'd0, cap_busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, cap_done}, 32'd0);
        chk({tag, "_err"}, {31'd0, cap_err}, 32'd0);
        chk({tag, "_trig_addr"}, 32'(trig_addr), 32'd0);
        chk({tag, "_wrapped"}, {31'd0, wrapped}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n5;
        model_reset();
        cyc = 0;
        track_clear();

        // Reset state.
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Wrap without trigger.
        cfg_trig_en = 1'b0; cfg_trig_mask = '0; cfg_trig_val = '0;
        arm();
        for (int i = 0; i < 1030; i++) smp(1'b1, $urandom);
        chk("wrap_wrapped", {31'd0, wrapped}, 32'd1);
        chk("wrap_busy", {31'd0, cap_busy}, 32'd1);
        chk("wrap_done", {31'd0, cap_done}, 32'd0);
        chk("wrap_last_addr", 32'(last_wa), 32'd5);
        chk("wrap_count", 32'(wr_count), 32'd1030);

        // Data-match trigger with post_len=4.
        cfg_abort = 1'b1;
        smp(1'b0, 32'd0);
        cfg_trig_en = 1'b1; cfg_trig_mask = 32'hFFFF_FFFF; cfg_trig_val = 32'h0000_ABCD;
        cfg_post_len = 16'd4;
        arm();
        for (int i = 0; i < 35; i++)
            smp(1'b1, (i == 20) ? 32'h0000_ABCD : (32'h0001_0000 | 32'(i)));
        chk("match_trig_addr", 32'(trig_addr), 32'd20);
        chk("match_last_addr", 32'(last_wa), 32'd24);
        chk("match_count", 32'(wr_count), 32'd25);
        chk("match_done", {31'd0, cap_done}, 32'd1);
        chk("match_done_lag", 32'(done_cyc - last_wr_cyc), 32'd1);

        // ext_trig while no valid sample, trigger lands on the next valid sample.
        cfg_trig_en = 1'b0; cfg_post_len = 16'd2;
        arm();
        for (int i = 0; i < 7; i++) smp(1'b1, 32'(i));
        ext_trig = 1'b1;
        smp(1'b0, 32'd0);
        smp(1'b0, 32'd0);
        for (int i = 0; i < 6; i++) smp(1'b1, 32'h100 + 32'(i));
        chk("ext_trig_addr", 32'(trig_addr), 32'd7);
        chk("ext_last_addr", 32'(last_wa), 32'd9);

        // Simultaneous data match and ext_trig: a single trigger, post count starts once.
        cfg_trig_en = 1'b1; cfg_trig_mask = 32'hFFFF_FFFF; cfg_trig_val = 32'h5A5A_5A5A;
        cfg_post_len = 16'd3;
        arm();
        for (int i = 0; i < 3; i++) smp(1'b1, 32'(i));
        ext_trig = 1'b1;
        smp(1'b1, 32'h5A5A_5A5A);
        for (int i = 0; i < 8; i++) smp(1'b1, 32'h5A5A_5A5A);
        chk("both_trig_addr", 32'(trig_addr), 32'd3);
        chk("both_count", 32'(wr_count), 32'd7);
        chk("both_done", {31'd0, cap_done}, 32'd1);

        // Post length clamp.
        cfg_trig_val = 32'h1234_5678; cfg_post_len = 16'hFFFF;
        arm();
        n5 = 0;
        for (int i = 0; i < 1100; i++) begin
            smp(1'b1, (i == 5) ? 32'h1234_5678 : 32'hC000_0000 + 32'(i));
            if (mem_wr_en && mem_waddr == AW'(5)) n5++;
        end
        chk("clamp_post_writes", 32'(wr_count - 6), 32'd1023);
        chk("clamp_trig_written_once", 32'(n5), 32'd1);
        chk("clamp_trig_addr", 32'(trig_addr), 32'd5);
        chk("clamp_done", {31'd0, cap_done}, 32'd1);

        // Abort on the trigger sample.
        cfg_trig_val = 32'h77; cfg_post_len = 16'd6;
        arm();
        smp(1'b1, 32'h1);
        smp(1'b1, 32'h2);
        cfg_abort = 1'b1;
        smp(1'b1, 32'h77);
        chk("abort_no_write", {31'd0, mem_wr_en}, 32'd0);
        chk("abort_busy", {31'd0, cap_busy}, 32'd0);
        smp(1'b1, 32'h77);
        chk("abort_done", {31'd0, cap_done}, 32'd0);
        chk("abort_count", 32'(wr_count), 32'd2);

        // cap_mode_vld dropped in POST.
        cfg_post_len = 16'd10;
        arm();
        smp(1'b1, 32'h77);
        for (int i = 0; i < 3; i++) smp(1'b1, 32'(i));
        cap_mode_vld = 1'b0;
        smp(1'b1, 32'h9);
        cap_mode_vld = 1'b1;
        chk("moderr_err", {31'd0, cap_err}, 32'd1);
        chk("moderr_busy", {31'd0, cap_busy}, 32'd0);
        chk("moderr_no_write", {31'd0, mem_wr_en}, 32'd0);

        // Reset while in POST, then re-arm.
        cfg_post_len = 16'd50;
        arm();
        smp(1'b1, 32'h77);
        for (int i = 0; i < 5; i++) smp(1'b1, 32'h40 + 32'(i));
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_post");
        model_reset();
        #1;
        rst_n = 1'b1;
        cfg_trig_en = 1'b0;
        arm();
        smp(1'b1, 32'hDEAD_BEEF);
        chk("rearm_wr_en", {31'd0, mem_wr_en}, 32'd1);
        chk("rearm_addr", 32'(mem_waddr), 32'd0);
        for (int i = 0; i < 4; i++) smp(1'b1, $urandom);

        // Randomized traffic against the model.
        for (int r = 0; r < 6; r++) begin
            cfg_post_len  = 16'($urandom_range(0, 40));
            cfg_trig_en   = 1'($urandom_range(0, 1));
            cfg_trig_mask = 32'h3;
            cfg_trig_val  = 32'($urandom_range(0, 3));
            arm();
            for (int k = 0; k < 300; k++) begin
                int p;
                p = $urandom_range(0, 199);
                ext_trig     = (p < 6);
                cfg_abort    = (p == 7);
                cap_mode_vld = (p != 8);
                cfg_arm      = (p >= 192);
                smp($urandom_range(0, 3) != 0, 32'($urandom_range(0, 15)));
            end
            cap_mode_vld = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
